// File: rtl/chunked_wide_adder.sv
// chunked_wide_adder: W-bit adder built from one (N+1)-bit ripple slice.
// One chunk is added per clock, least-significant chunk first. The carry
// between chunks is held in a register. Operands come in over a valid/ready
// handshake and the result goes out over a second valid/ready handshake.
`timescale 1ns/1ps

module chunked_wide_adder #(
    parameter int W = 16,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         busy
);

    // Slice width and chunk count. W must be a multiple of the slice width.
    localparam int S  = N + 1;
    localparam int C  = W / S;
    localparam int IW = (C > 1) ? $clog2(C) : 1;

    localparam logic [W-1:0] LANE_MASK = W'({S{1'b1}});
    localparam logic [IW-1:0] LAST_IDX = IW'(C - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           cry;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

    logic [31:0]    shamt;
    logic [S-1:0]   slice_x;
    logic [S-1:0]   slice_y;
    logic [S-1:0]   slice_s;
    logic           slice_c;
    logic           ripple;
    logic [W-1:0]   sum_next;

    // Handshake and status flags are pure decodes of the state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Bit offset of the chunk currently being added.
    assign shamt = 32'(idx) * 32'(S);

    // Ripple-carry slice over the current chunk, fed by the carry register.
    always_comb begin
        // NOTE: every variable gets a value before any conditional or loop
        // logic, so no path can leave it unassigned and infer a latch.
        slice_x = S'(op_a >> shamt);
        slice_y = S'(op_b >> shamt);
        slice_s = '0;
        ripple  = cry;
        for (int i = 0; i < S; i++) begin
            slice_s[i] = slice_x[i] ^ slice_y[i] ^ ripple;
            ripple     = (slice_x[i] & slice_y[i]) | (ripple & (slice_x[i] ^ slice_y[i]));
        end
        slice_c  = ripple;
        sum_next = (sum & ~(LANE_MASK << shamt)) | (W'(slice_s) << shamt);
    end

    // Control FSM plus datapath registers; reset abandons any operation.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cry   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        cry   <= cin;
                        sum   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum <= sum_next;
                    cry <= slice_c;
                    if (idx == LAST_IDX) begin
                        carry <= slice_c;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
